// File: rtl/pv2long_core_dpath_muldiv_wb_pkg.sv
// Shared types for the muldiv writeback stage: fn codes, tag layout, hi/lo select.
// Optional: PV2LONG_MULDIV_WB_MULH_EN makes fn 5 (mulh) select the high word.
package pv2long_core_dpath_muldiv_wb_pkg;

  localparam logic [2:0] MULDIV_MUL  = 3'd0;
  localparam logic [2:0] MULDIV_DIV  = 3'd1;
  localparam logic [2:0] MULDIV_DIVU = 3'd2;
  localparam logic [2:0] MULDIV_REM  = 3'd3;
  localparam logic [2:0] MULDIV_REMU = 3'd4;
  localparam logic [2:0] MULDIV_MULH = 3'd5;

  localparam int FN_W    = 3;
  localparam int WADDR_W = 5;
  localparam int TAG_W   = FN_W + WADDR_W;

  typedef struct packed {
    logic [FN_W-1:0]    fn;
    logic [WADDR_W-1:0] waddr;
  } tag_t;

  // remainders live in the high half of the muldiv response
  function automatic logic sel_hi(input logic [FN_W-1:0] fn);
    logic hi;
    hi = (fn == MULDIV_REM) || (fn == MULDIV_REMU);
`ifdef PV2LONG_MULDIV_WB_MULH_EN
    hi = hi || (fn == MULDIV_MULH);
`endif
    return hi;
  endfunction

endpackage

// File: rtl/pv2long_core_dpath_muldiv_wb_tag_fifo.sv
// Generic DEPTH x W circular FIFO that also exposes per-entry occupancy and one
// field of every entry, so the owner can build a pending-register mask.
module pv2long_muldiv_tag_fifo #(
  parameter int DEPTH   = 4,
  parameter int PTR_W   = 2,
  parameter int W       = 8,
  parameter int VIS_LSB = 0,
  parameter int VIS_W   = 5
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            push,
  input  logic [W-1:0]                    push_data,
  output logic                            push_rdy,
  input  logic                            pop,
  output logic [W-1:0]                    head,
  output logic [PTR_W:0]                  count,
  output logic [DEPTH-1:0]                occ,
  output logic [DEPTH-1:0][VIS_W-1:0]     entries
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // full decode comes straight off the count register, never from pop
  assign push_rdy = (count != (PTR_W+1)'(DEPTH));
  assign push_ok  = push && push_rdy;
  assign pop_ok   = pop && (count != '0);
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset && push && !push_rdy)
      $display("pv2long_muldiv_tag_fifo: tag push while full ignored at %0t", $time);
  end
`endif

  // entry i is live when its distance from the read pointer is below count
  always_comb begin
    logic [PTR_W-1:0] off;
    off     = '0;
    occ     = '0;
    entries = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off        = PTR_W'(i) - rd_ptr;
      occ[i]     = ({1'b0, off} < count);
      entries[i] = mem[i][VIS_LSB +: VIS_W];
    end
  end

endmodule

// File: rtl/pv2long_core_dpath_muldiv_wb.sv
// Muldiv writeback stage: pairs in-order muldiv responses with issue-time tags,
// selects the 32-bit result and holds it for the register file under val/rdy.
// Optional: PV2LONG_MULDIV_WB_MULH_EN (see package sel_hi).
module pv2long_core_dpath_muldiv_wb
  import pv2long_core_dpath_muldiv_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tag_val,
  input  logic [2:0]  tag_fn,
  input  logic [4:0]  tag_waddr,
  output logic        tag_rdy,
  input  logic [63:0] muldivresp_msg_result,
  input  logic        muldivresp_val,
  output logic        muldivresp_rdy,
  output logic        wb_val,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_data,
  input  logic        wb_rdy,
  output logic [31:0] pend_mask,
  output logic        busy
);

  tag_t                            head_tag;
  logic [PTR_W:0]                  count;
  logic [DEPTH-1:0]                occ;
  logic [DEPTH-1:0][WADDR_W-1:0]   ent_waddr;
  logic                            fire;
  logic [31:0]                     res_sel;

  pv2long_muldiv_tag_fifo #(
    .DEPTH   (DEPTH),
    .PTR_W   (PTR_W),
    .W       (TAG_W),
    .VIS_LSB (0),
    .VIS_W   (WADDR_W)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tag_val),
    .push_data ({tag_fn, tag_waddr}),
    .push_rdy  (tag_rdy),
    .pop       (fire),
    .head      (head_tag),
    .count     (count),
    .occ       (occ),
    .entries   (ent_waddr)
  );

  assign muldivresp_rdy = (count != '0) && (!wb_val || wb_rdy);
  assign fire           = muldivresp_val && muldivresp_rdy;
  assign res_sel        = sel_hi(head_tag.fn) ? muldivresp_msg_result[63:32]
                                              : muldivresp_msg_result[31:0];

  // output register stage: reload on fire, retire on wb_rdy, otherwise hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_val   <= 1'b0;
      wb_waddr <= '0;
      wb_data  <= '0;
    end else if (fire) begin
      wb_val   <= 1'b1;
      wb_waddr <= head_tag.waddr;
      wb_data  <= res_sel;
    end else if (wb_rdy) begin
      wb_val   <= 1'b0;
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occ[i]) pend_mask[ent_waddr[i]] = 1'b1;
    end
    if (wb_val) pend_mask[wb_waddr] = 1'b1;
  end

  assign busy = (count != '0) || wb_val;

endmodule

// File: tb/tb_pv2long_core_dpath_muldiv_wb.sv
// Directed bench for the muldiv writeback stage; inputs change and outputs are
// sampled on the falling edge, away from the active rising edge.
module tb_pv2long_core_dpath_muldiv_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic        tag_val;
  logic [2:0]  tag_fn;
  logic [4:0]  tag_waddr;
  logic        tag_rdy;
  logic [63:0] muldivresp_msg_result;
  logic        muldivresp_val;
  logic        muldivresp_rdy;
  logic        wb_val;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_data;
  logic        wb_rdy;
  logic [31:0] pend_mask;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pv2long_core_dpath_muldiv_wb #(.DEPTH(4), .PTR_W(2)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .tag_val               (tag_val),
    .tag_fn                (tag_fn),
    .tag_waddr             (tag_waddr),
    .tag_rdy               (tag_rdy),
    .muldivresp_msg_result (muldivresp_msg_result),
    .muldivresp_val        (muldivresp_val),
    .muldivresp_rdy        (muldivresp_rdy),
    .wb_val                (wb_val),
    .wb_waddr              (wb_waddr),
    .wb_data               (wb_data),
    .wb_rdy                (wb_rdy),
    .pend_mask             (pend_mask),
    .busy                  (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_tag(input logic v, input logic [2:0] fn, input logic [4:0] wa);
    tag_val   = v;
    tag_fn    = fn;
    tag_waddr = wa;
  endtask

  task automatic set_resp(input logic v, input logic [63:0] r);
    muldivresp_val        = v;
    muldivresp_msg_result = r;
  endtask

  task automatic chk_wb(input string tag, input logic v, input logic [4:0] wa, input logic [31:0] d);
    chk({tag, "_val"}, 64'(wb_val), 64'(v));
    chk({tag, "_waddr"}, 64'(wb_waddr), 64'(wa));
    chk({tag, "_data"}, 64'(wb_data), 64'(d));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] exp_wa [9];
    exp_wa = '{5'd2, 5'd3, 5'd4, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};

    reset = 1'b0;
    set_tag(1'b0, 3'd0, 5'd0);
    set_resp(1'b0, 64'h0);
    wb_rdy = 1'b1;
    #1;
    chk("rst_wb_val", 64'(wb_val), 64'd0);
    chk("rst_wb_data", 64'(wb_data), 64'd0);
    chk("rst_tag_rdy", 64'(tag_rdy), 64'd1);
    chk("rst_resp_rdy", 64'(muldivresp_rdy), 64'd0);
    chk("rst_pend", 64'(pend_mask), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    cyc();
    reset = 1'b1;
    cyc();

    // 1: single mul
    set_tag(1'b1, 3'd0, 5'd3);
    cyc();
    set_tag(1'b0, 3'd0, 5'd0);
    #1;
    chk("t1_pend_q", 64'(pend_mask), 64'h8);
    chk("t1_busy", 64'(busy), 64'd1);
    set_resp(1'b1, 64'hffffffff_ffffffc0);
    #1;
    chk("t1_resp_rdy", 64'(muldivresp_rdy), 64'd1);
    cyc();
    set_resp(1'b0, 64'h0);
    chk_wb("t1_wb", 1'b1, 5'd3, 32'hffffffc0);
    chk("t1_pend_wb", 64'(pend_mask), 64'h8);
    cyc();
    chk("t1_retire", 64'(wb_val), 64'd0);
    chk("t1_pend_clr", 64'(pend_mask), 64'd0);
    chk("t1_idle", 64'(busy), 64'd0);

    // 2: rem then div back to back
    set_tag(1'b1, 3'd3, 5'd7);
    cyc();
    set_tag(1'b1, 3'd1, 5'd8);
    cyc();
    set_tag(1'b0, 3'd0, 5'd0);
    set_resp(1'b1, 64'h0000002e_0000000a);
    cyc();
    chk_wb("t2_wb0", 1'b1, 5'd7, 32'h0000002e);
    set_resp(1'b1, 64'h00003372_ffffdf75);
    cyc();
    set_resp(1'b0, 64'h0);
    chk_wb("t2_wb1", 1'b1, 5'd8, 32'hffffdf75);
    cyc();
    chk("t2_retire", 64'(wb_val), 64'd0);

    // 3: fill, overflow attempt, pop, wrap
    for (int i = 1; i <= 4; i++) begin
      set_tag(1'b1, 3'd0, 5'(i));
      cyc();
    end
    set_tag(1'b0, 3'd0, 5'd0);
    #1;
    chk("t3_full_rdy", 64'(tag_rdy), 64'd0);
    chk("t3_full_pend", 64'(pend_mask), 64'h1e);
    chk("t3_full_busy", 64'(busy), 64'd1);
    set_tag(1'b1, 3'd0, 5'd10);
    cyc();
    set_tag(1'b0, 3'd0, 5'd0);
    chk("t3_ovf_pend", 64'(pend_mask), 64'h1e);
    set_resp(1'b1, 64'h0000000f_00000011);
    cyc();
    set_resp(1'b0, 64'h0);
    chk_wb("t3_pop", 1'b1, 5'd1, 32'h00000011);
    chk("t3_rdy_back", 64'(tag_rdy), 64'd1);
    chk("t3_pend_pop", 64'(pend_mask), 64'h1e);
    for (int k = 0; k < 9; k++) begin
      set_tag(1'b1, 3'd0, 5'(10 + k));
      set_resp(1'b1, 64'(32'h100 + k));
      cyc();
      chk("t3_wrap_waddr", 64'(wb_waddr), 64'(exp_wa[k]));
      chk("t3_wrap_data", 64'(wb_data), 64'(32'h100 + k));
    end
    set_tag(1'b0, 3'd0, 5'd0);
    for (int j = 0; j < 3; j++) begin
      set_resp(1'b1, 64'(32'h200 + j));
      cyc();
      chk_wb("t3_drain", 1'b1, 5'(16 + j), 32'h200 + j);
    end
    set_resp(1'b0, 64'h0);
    cyc();
    chk("t3_empty_busy", 64'(busy), 64'd0);
    chk("t3_empty_pend", 64'(pend_mask), 64'd0);

    // 4: stall with second response pending
    set_tag(1'b1, 3'd0, 5'd5);
    cyc();
    set_tag(1'b1, 3'd0, 5'd6);
    cyc();
    set_tag(1'b0, 3'd0, 5'd0);
    wb_rdy = 1'b0;
    set_resp(1'b1, 64'h55);
    cyc();
    chk_wb("t4_first", 1'b1, 5'd5, 32'h55);
    set_resp(1'b1, 64'h66);
    #1;
    chk("t4_stall_rdy", 64'(muldivresp_rdy), 64'd0);
    cyc();
    chk_wb("t4_hold", 1'b1, 5'd5, 32'h55);
    chk("t4_hold_pend", 64'(pend_mask), 64'h60);
    wb_rdy = 1'b1;
    #1;
    chk("t4_release_rdy", 64'(muldivresp_rdy), 64'd1);
    cyc();
    set_resp(1'b0, 64'h0);
    chk_wb("t4_reload", 1'b1, 5'd6, 32'h66);
    cyc();
    chk("t4_retire", 64'(wb_val), 64'd0);

    // 5: response ahead of its tag
    set_resp(1'b1, 64'h77);
    set_tag(1'b1, 3'd0, 5'd12);
    #1;
    chk("t5_empty_rdy", 64'(muldivresp_rdy), 64'd0);
    cyc();
    set_tag(1'b0, 3'd0, 5'd0);
    chk("t5_no_wb", 64'(wb_val), 64'd0);
    #1;
    chk("t5_now_rdy", 64'(muldivresp_rdy), 64'd1);
    cyc();
    set_resp(1'b0, 64'h0);
    chk_wb("t5_wb", 1'b1, 5'd12, 32'h77);
    cyc();

    // 6: reset mid-stream, then remu and fn5
    for (int i = 20; i <= 23; i++) begin
      set_tag(1'b1, 3'd0, 5'(i));
      cyc();
    end
    set_tag(1'b0, 3'd0, 5'd0);
    wb_rdy = 1'b0;
    set_resp(1'b1, 64'h99);
    cyc();
    set_resp(1'b0, 64'h0);
    chk("t6_pre_val", 64'(wb_val), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_rst_val", 64'(wb_val), 64'd0);
    chk("t6_rst_pend", 64'(pend_mask), 64'd0);
    chk("t6_rst_tag_rdy", 64'(tag_rdy), 64'd1);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    cyc();
    reset = 1'b1;
    wb_rdy = 1'b1;
    cyc();
    chk("t6_post_val", 64'(wb_val), 64'd0);
    set_tag(1'b1, 3'd4, 5'd9);
    cyc();
    set_tag(1'b0, 3'd0, 5'd0);
    set_resp(1'b1, 64'hf5fe4fbc_00000000);
    cyc();
    set_resp(1'b0, 64'h0);
    chk_wb("t6_remu", 1'b1, 5'd9, 32'hf5fe4fbc);
    set_tag(1'b1, 3'd5, 5'd10);
    cyc();
    set_tag(1'b0, 3'd0, 5'd0);
    set_resp(1'b1, 64'h12345678_9abcdef0);
    cyc();
    set_resp(1'b0, 64'h0);
`ifdef PV2LONG_MULDIV_WB_MULH_EN
    chk_wb("t6_fn5", 1'b1, 5'd10, 32'h12345678);
`else
    chk_wb("t6_fn5", 1'b1, 5'd10, 32'h9abcdef0);
`endif
    set_tag(1'b1, 3'd6, 5'd11);
    cyc();
    set_tag(1'b0, 3'd0, 5'd0);
    set_resp(1'b1, 64'h12345678_9abcdef0);
    cyc();
    set_resp(1'b0, 64'h0);
    chk_wb("t6_fn6", 1'b1, 5'd11, 32'h9abcdef0);
    cyc();
    chk("t6_idle", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pv2long_core_dpath_muldiv_wb.md
Name: pv2long_core_dpath_muldiv_wb

Overview:
Writeback stage directly downstream of the pipelined muldiv unit (parc_CoreDpathPipeMulDiv).
- A tag FIFO records fn and destination register for every muldiv request at issue.
- Each 64-bit muldiv response is paired in order with the oldest tag.
- The stage selects the 32-bit architectural result, registers it, and presents it to register-file writeback under val/rdy.
- It exports a pending-destination mask for the decode-stage scoreboard.

Parameters:
DEPTH, 4, tag FIFO entries; power of two, >=2; must cover the muldiv unit's maximum in-flight count.
PTR_W, 2, log2(DEPTH).

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
tag_val  input  1  push a tag; asserted exactly when muldivreq fires (val&&rdy).
tag_fn  input  3  muldiv fn: 0 mul, 1 div, 2 divu, 3 rem, 4 remu.
tag_waddr  input  5  destination register.
tag_rdy  output  1  FIFO not full; upstream ANDs it into muldivreq_val.
muldivresp_msg_result  input  64  {hi, lo} from the muldiv unit.
muldivresp_val  input  1  response valid.
muldivresp_rdy  output  1  stage accepts a response.
wb_val  output  1  writeback valid.
wb_waddr  output  5  writeback register.
wb_data  output  32  writeback value.
wb_rdy  input  1  register file accepts the writeback.
pend_mask  output  32  bit r set iff any occupied FIFO entry or a valid output register targets r.
busy  output  1  FIFO non-empty or wb_val.

Behaviour:
Reset (reset low, asynchronous):
- Pointers, count, wb_val cleared; wb_waddr and wb_data cleared to 0.
- tag_rdy=1, muldivresp_rdy=0, pend_mask=0, busy=0.
- Mid-operation reset discards all tags and the held result; no writeback is emitted.

Tag FIFO:
- Circular buffer with wrapping pointers and a count register of width PTR_W+1.
- tag_rdy = (count != DEPTH), a pure register decode with no combinational path from pop.
- Push happens when tag_val && tag_rdy. tag_val while full is a protocol error: ignored, and flagged with a simulation-only $display.
- Push and pop in the same cycle leave count unchanged and advance both pointers.

Response acceptance:
- muldivresp_rdy = (count != 0) && (!wb_val || wb_rdy).
- No bypass: a tag pushed in cycle N can pair with a response no earlier than cycle N+1.

On response fire (muldivresp_val && muldivresp_rdy):
- Pop the head tag.
- Load the output register at the next edge: wb_waddr = tag waddr.
- wb_data = result[63:32] for fn 3/4, otherwise result[31:0].
- Latency: fire in cycle N gives wb_val high in cycle N+1.

Output register:
- Holds its value while wb_val && !wb_rdy.
- wb_val clears on wb_rdy unless a new fire reloads it in the same cycle. Back-to-back fires sustain one writeback per cycle.
- fn 5-7 select lo; see the optional feature for fn 5.

pend_mask and busy:
- pend_mask is combinational: OR of one-hot(waddr) over occupied entries, plus one-hot(wb_waddr) when wb_val.
- Register 0 is included in the mask with no special casing.
- busy is combinational.

Ordering:
- The muldiv unit returns responses in order, so tag order equals response order.

Optional Feature:
PV2LONG_MULDIV_WB_MULH_EN
- Defined: fn 5 (mulh) selects result[63:32]; fn 6-7 select lo.
- Undefined: fn 5-7 select lo. The decoder never issues mulh.

Decomposition:
Shared package / include header pv2long-MulDivWbTypes.v:
- fn code localparams (MULDIV_MUL=0, DIV=1, DIVU=2, REM=3, REMU=4, MULH=5).
- Tag width constant (8 = fn + waddr).
- Function sel_hi(fn) returning the hi/lo select.

One sub-module: pv2long_muldiv_tag_fifo, a generic DEPTH x 8 FIFO that also exposes an occupied-entry vector and the entry array for pend_mask generation. Result select and the output register stay in the top module.

Test Plan:
1. Tag fn0/waddr3, then response ffffffff_ffffffc0 -> next cycle wb_val=1, wb_waddr=3, wb_data=ffffffc0; pend_mask bit3 clears after wb_rdy.
2. Tags fn3/waddr7, fn1/waddr8; responses 0000002e_0000000a, 00003372_ffffdf75 back-to-back with wb_rdy=1 -> writebacks (7, 0000002e) then (8, ffffdf75) on consecutive cycles.
3. Push 4 tags (waddr 1,2,3,4) with no responses -> tag_rdy=0, pend_mask=0000001e, busy=1. A fifth tag_val is ignored. One response pops -> tag_rdy=1 next cycle. Run 9 further tags to wrap the pointers.
4. wb_rdy=0 with wb_val=1 and a second response valid -> muldivresp_rdy=0, output held stable. Raise wb_rdy -> held value retires and the new one loads the same cycle.
5. Response valid with empty FIFO -> muldivresp_rdy=0, no writeback. Tag pushed same cycle -> accepted next cycle.
6. Assert reset low mid-stream with 3 tags queued and wb_val=1 -> immediately wb_val=0, pend_mask=0, tag_rdy=1. After release, fn4 response f5fe4fbc_00000000 with a fresh tag (waddr 9) -> wb_data=f5fe4fbc. With the macro defined, fn5 response 12345678_9abcdef0 -> wb_data=12345678.
